// File: rtl/ca_row_engine.sv
// ca_row_engine: elementary (Wolfram-rule) 1-D cellular-automaton engine.
// Holds the current generation, an H-deep history of rows and a generation
// counter. Runs single-step or free-running with a programmable period.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rule[7:0]             Wolfram rule applied at each commit
//   bound_mode[1:0]       edge condition: 00 zero, 01 one, 10 wrap, 11 reflect
//   seed[W-1:0], load     load pattern (top priority), clears counters
//   step                  single generation from IDLE
//   run, period[PW-1:0]   free-run, one generation every max(period,1) cycles
//   halt_on_stable        enter HALT when a generation equals its predecessor
//   cur_row[W-1:0]        current generation (history row 0)
//   history[W*H-1:0]      row k at [k*W +: W], row 0 newest
//   gen_count[GW-1:0]     generations since load, saturating
//   gen_valid             one-cycle pulse after each commit
//   stable                last commit equalled its predecessor
//   state[1:0]            00 IDLE, 01 RUN, 10 HALT
module ca_row_engine #(
  parameter int unsigned W  = 16,
  parameter int unsigned H  = 16,
  parameter int unsigned PW = 24,
  parameter int unsigned GW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rule,
  input  logic [1:0]        bound_mode,
  input  logic [W-1:0]      seed,
  input  logic              load,
  input  logic              step,
  input  logic              run,
  input  logic [PW-1:0]     period,
  input  logic              halt_on_stable,
  output logic [W-1:0]      cur_row,
  output logic [W*H-1:0]    history,
  output logic [GW-1:0]     gen_count,
  output logic              gen_valid,
  output logic              stable,
  output logic [1:0]        state
);

  localparam logic [1:0] BM_ZERO    = 2'b00;
  localparam logic [1:0] BM_ONE     = 2'b01;
  localparam logic [1:0] BM_WRAP    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t                 r_state;
  logic [H-1:0][W-1:0]    r_hist;
  logic [GW-1:0]          r_gen;
  logic [PW-1:0]          r_tick;
  logic                   r_gen_valid;
  logic                   r_stable;

  logic [W-1:0]           w_cur;
  logic                   w_left_edge;
  logic                   w_right_edge;
  logic [W+1:0]           w_ext;
  logic [W-1:0]           w_next;
  logic [PW-1:0]          w_per_m1;
  logic                   w_commit;
  logic                   w_next_stable;
  logic [GW-1:0]          w_gen_inc;

  assign w_cur = r_hist[0];

  // Neighbour fed into the left of cell W-1 and the right of cell 0
  always_comb begin
    w_left_edge  = 1'b0;
    w_right_edge = 1'b0;
    case (bound_mode)
      BM_ZERO: begin
        w_left_edge  = 1'b0;
        w_right_edge = 1'b0;
      end
      BM_ONE: begin
        w_left_edge  = 1'b1;
        w_right_edge = 1'b1;
      end
      BM_WRAP: begin
        w_left_edge  = w_cur[0];
        w_right_edge = w_cur[W-1];
      end
      default: begin
        w_left_edge  = w_cur[W-1];
        w_right_edge = w_cur[0];
      end
    endcase
  end

  // Row padded with edge neighbours; cell i sees {ext[i+2], ext[i+1], ext[i]}
  assign w_ext = {w_left_edge, w_cur, w_right_edge};

  always_comb begin
    w_next = '0;
    for (int i = 0; i < int'(W); i++) begin
      w_next[i] = rule[w_ext[i +: 3]];
    end
  end

  assign w_next_stable = (w_next == w_cur);

  // Period of 0 behaves as 1
  assign w_per_m1 = (period == '0) ? '0 : period - PW'(1);

  assign w_gen_inc = (r_gen == '1) ? r_gen : r_gen + GW'(1);

  // A generation is committed this edge (load always suppresses it).
  // >= keeps the free-run cadence sane if period shrinks below the live tick.
  assign w_commit = !load &&
                    (((r_state == S_IDLE) && !run && step) ||
                     ((r_state == S_RUN) && run && (r_tick >= w_per_m1)));

  // Row/history/counter datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist   <= '0;
      r_gen    <= '0;
      r_stable <= 1'b0;
    end else if (load) begin
      r_hist    <= '0;
      r_hist[0] <= seed;
      r_gen     <= '0;
      r_stable  <= 1'b0;
    end else if (w_commit) begin
      for (int j = int'(H) - 1; j > 0; j--) begin
        r_hist[j] <= r_hist[j-1];
      end
      r_hist[0] <= w_next;
      r_gen     <= w_gen_inc;
      r_stable  <= w_next_stable;
    end
  end

  // Control FSM with tick counter and gen_valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_gen_valid <= 1'b0;
    end else begin
      r_gen_valid <= w_commit;
      if (load) begin
        r_state <= S_IDLE;
        r_tick  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (run) begin
              r_state <= S_RUN;
              r_tick  <= '0;
            end else if (w_commit && w_next_stable && halt_on_stable) begin
              r_state <= S_HALT;
            end
          end
          S_RUN: begin
            if (!run) begin
              r_state <= S_IDLE;
              r_tick  <= '0;
            end else if (w_commit) begin
              r_tick <= '0;
              if (w_next_stable && halt_on_stable) begin
                r_state <= S_HALT;
              end
            end else begin
              r_tick <= r_tick + PW'(1);
            end
          end
          S_HALT: begin
            if (!halt_on_stable) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tick  <= '0;
          end
        endcase
      end
    end
  end

  assign cur_row   = r_hist[0];
  assign history   = r_hist;
  assign gen_count = r_gen;
  assign gen_valid = r_gen_valid;
  assign stable    = r_stable;
  assign state     = r_state;

endmodule
